// File: rtl/stream_pipe_rx.sv
// stream_pipe_rx: valid/ready register pipeline with a one-entry skid ahead of
// stage 0. It collapses bubbles, holds data while the consumer stalls, and
// keeps the stall-free latency of a plain NUM_STAGES delay line.
module stream_pipe_rx #(
  parameter int NUM_STAGES = 2,
  parameter int DATA_WIDTH = 2
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              S_VALID,
  output logic                              S_READY,
  input  logic [DATA_WIDTH-1:0]             S_DATA,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic [DATA_WIDTH-1:0]             M_DATA,
  output logic [$clog2(NUM_STAGES+2)-1:0]   COUNT
);

  localparam int COUNT_W = $clog2(NUM_STAGES + 2);

  generate
    if (NUM_STAGES == 0) begin : g_passthru

      // Zero stages: a wire, no storage and nothing to count.
      assign M_VALID = S_VALID;
      assign M_DATA  = S_DATA;
      assign S_READY = M_READY;
      assign COUNT   = '0;

    end else begin : g_pipe

      localparam int LAST = NUM_STAGES - 1;

      logic [NUM_STAGES-1:0] v;
      logic [DATA_WIDTH-1:0] d [NUM_STAGES];
      logic                  sv;
      logic [DATA_WIDTH-1:0] sd;

      logic [NUM_STAGES-1:0] ld;
      logic                  in_xfer;
      logic                  out_xfer;
      logic                  src_v;
      logic [DATA_WIDTH-1:0] src_d;
      logic                  sv_next;

      assign M_VALID  = v[LAST];
      assign M_DATA   = d[LAST];
      assign in_xfer  = S_VALID & S_READY;
      assign out_xfer = v[LAST] & M_READY;

      // Load enables ripple back from the output: a stage loads when it is
      // empty or when its successor takes its word this cycle.
      always_comb begin
        logic chain;
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        ld    = '0;
        chain = ~v[LAST] | M_READY;
        ld[LAST] = chain;
        for (int k = LAST - 1; k >= 0; k--) begin
          chain = ~v[k] | chain;
          ld[k] = chain;
        end
      end

      // Stage 0 source selection and next skid occupancy. The skid, when
      // full, always feeds stage 0 first to keep strict FIFO order.
      always_comb begin
        src_v   = sv | in_xfer;
        src_d   = sv ? sd : S_DATA;
        sv_next = 1'b0;
        if (sv) begin
          sv_next = ld[0] ? in_xfer : 1'b1;
        end else begin
          sv_next = in_xfer & ~ld[0];
        end
      end

      // Pipeline, skid, registered ready and occupancy count.
      always_ff @(posedge CLK) begin
        if (!RESET) begin
          // NOTE: the data registers are reset as well so M_DATA reads 0 after
          // reset; this is a handful of flops, not a RAM, so it is cheap.
          v       <= '0;
          sv      <= 1'b0;
          sd      <= '0;
          S_READY <= 1'b0;
          COUNT   <= '0;
          for (int k = 0; k < NUM_STAGES; k++) begin
            d[k] <= '0;
          end
        end else begin
          // NOTE: non-blocking assignments so every stage sees its
          // predecessor's pre-edge value and words shift by exactly one stage.
          if (ld[0]) begin
            v[0] <= src_v;
            if (src_v) begin
              d[0] <= src_d;
            end
          end
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (ld[k]) begin
              v[k] <= v[k-1];
              if (v[k-1]) begin
                d[k] <= d[k-1];
              end
            end
          end
          sv <= sv_next;
          if (in_xfer && sv_next) begin
            sd <= S_DATA;
          end
          S_READY <= ~sv_next;
          COUNT   <= COUNT + COUNT_W'(in_xfer) - COUNT_W'(out_xfer);
        end
      end

    end
  endgenerate

endmodule

// File: tb/tb_stream_pipe_rx.sv
// Self-checking bench for stream_pipe_rx: a NUM_STAGES=2 instance driven by
// directed scenarios with a FIFO scoreboard, plus a NUM_STAGES=0 instance
// checked as a combinational pass-through.
module tb_stream_pipe_rx;

  localparam int NS    = 2;
  localparam int DW    = 2;
  localparam int CW    = $clog2(NS + 2);
  localparam int DEPTH = NS + 1;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b0;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data  = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;

  logic          z_s_valid = 1'b0;
  logic          z_s_ready;
  logic [DW-1:0] z_s_data  = '0;
  logic          z_m_valid;
  logic          z_m_ready = 1'b0;
  logic [DW-1:0] z_m_data;
  logic [0:0]    z_count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q   [$];
  logic [DW-1:0] got [$];
  bit            last_in;
  bit            last_out;
  int            n_out = 0;

  stream_pipe_rx #(.NUM_STAGES(NS), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
    .COUNT(count)
  );

  stream_pipe_rx #(.NUM_STAGES(0), .DATA_WIDTH(DW)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .S_VALID(z_s_valid), .S_READY(z_s_ready), .S_DATA(z_s_data),
    .M_VALID(z_m_valid), .M_READY(z_m_ready), .M_DATA(z_m_data),
    .COUNT(z_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle. Called at a negedge with inputs already set; evaluates
  // the handshakes, updates the scoreboard, crosses the posedge, and checks
  // COUNT / S_READY against the scoreboard occupancy at the next negedge.
  task automatic step();
    logic          in_h;
    logic          out_h;
    logic          rst_edge;
    logic [DW-1:0] exp_d;
    #1;
    in_h     = RESET && s_valid && (s_ready === 1'b1);
    out_h    = RESET && (m_valid === 1'b1) && m_ready;
    rst_edge = RESET;
    if (!RESET) q.delete();
    if (out_h) begin
      checks++;
      n_out++;
      got.push_back(m_data);
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_out: got data %0h, no word expected", m_data);
      end else begin
        exp_d = q.pop_front();
        if (m_data !== exp_d) begin
          errors++;
          $display("FAIL sb_order: got %0h expected %0h", m_data, exp_d);
        end
      end
    end
    if (in_h) q.push_back(s_data);
    last_in  = in_h;
    last_out = out_h;
    @(negedge CLK);
    checks++;
    if (count !== CW'(q.size())) begin
      errors++;
      $display("FAIL count_model: got %0d expected %0d", count, q.size());
    end
    checks++;
    if (s_ready !== (rst_edge && (q.size() != DEPTH))) begin
      errors++;
      $display("FAIL s_ready_model: got %0b expected %0b", s_ready,
               rst_edge && (q.size() != DEPTH));
    end
    if (m_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stale_valid: M_VALID=1 with data %0h and nothing held", m_data);
      end
    end
  endtask

  task automatic test_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    RESET   = 1'b0;
    @(negedge CLK);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
    checks++;
    if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    step();
    RESET = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b expected 1", s_ready); end
  endtask

  task automatic test_stream();
    int peak = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = (i < 4);
      s_data  = DW'(i);
      step();
      if (int'(count) > peak) peak = int'(count);
      if (i < 4) begin
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: cycle %0d got %0b expected 1", i, s_ready); end
      end
      checks++;
      if (i == 0) begin
        if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: M_VALID got %0b expected 0 one edge after accept", m_valid); end
      end else if (i <= 4) begin
        if (m_valid !== 1'b1 || m_data !== DW'(i - 1)) begin
          errors++;
          $display("FAIL stream_data: cycle %0d got valid %0b data %0h expected valid 1 data %0h",
                   i, m_valid, m_data, i - 1);
        end
      end else begin
        if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: M_VALID got %0b expected 0", m_valid); end
      end
    end
    checks++;
    if (peak != 2) begin errors++; $display("FAIL stream_peak_count: got %0d expected 2", peak); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] words [4];
    int idx = 0;
    words[0] = 2'd1; words[1] = 2'd2; words[2] = 2'd3; words[3] = 2'd0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_data = words[idx < 4 ? idx : 3];
      step();
      if (last_in) begin
        idx++;
        if (idx == 3) begin
          checks++;
          if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_drop: got %0b expected 0", s_ready); end
        end
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 2'd1) begin errors++; $display("FAIL stall_hold: got %0h expected 1", m_data); end
      end
    end
    checks++;
    if (idx != 3) begin errors++; $display("FAIL stall_accepts: got %0d expected 3", idx); end
    checks++;
    if (count !== CW'(3)) begin errors++; $display("FAIL stall_count: got %0d expected 3", count); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 2'd1) begin
      errors++;
      $display("FAIL stall_out: got valid %0b data %0h expected valid 1 data 1", m_valid, m_data);
    end
  endtask

  task automatic test_pulse();
    int guard = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 2'd0;
    got.delete();
    step();
    checks++;
    if (!last_out || last_in) begin
      errors++;
      $display("FAIL pulse_xfer: got out %0b in %0b expected out 1 in 0", last_out, last_in);
    end
    checks++;
    if (got.size() != 1 || got[0] !== 2'd1) begin errors++; $display("FAIL pulse_first: expected word 1 consumed"); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL pulse_ready_back: got %0b expected 1", s_ready); end
    m_ready = 1'b0;
    step();
    checks++;
    if (!last_in) begin errors++; $display("FAIL pulse_accept0: got in %0b expected 1", last_in); end
    s_valid = 1'b0;
    m_ready = 1'b1;
    got.delete();
    while (q.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL pulse_drain_timeout: %0d words left, expected 0", q.size()); end
    checks++;
    if (got.size() != 3 || got[0] !== 2'd2 || got[1] !== 2'd3 || got[2] !== 2'd0) begin
      errors++;
      $display("FAIL pulse_drain: got %0d words expected 2,3,0", got.size());
    end
  endtask

  task automatic test_bubble();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 2'd1; step();
    s_valid = 1'b0; step(); step();
    s_valid = 1'b1; s_data = 2'd2; step();
    s_valid = 1'b0; step(); step();
    checks++;
    if (count !== CW'(2)) begin errors++; $display("FAIL bubble_count: got %0d expected 2", count); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 2'd1) begin
      errors++;
      $display("FAIL bubble_head: got valid %0b data %0h expected valid 1 data 1", m_valid, m_data);
    end
    m_ready = 1'b1;
    got.delete();
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 2'd2) begin
      errors++;
      $display("FAIL bubble_collapse: got valid %0b data %0h expected valid 1 data 2", m_valid, m_data);
    end
    step();
    checks++;
    if (got.size() != 2 || got[0] !== 2'd1 || got[1] !== 2'd2) begin
      errors++;
      $display("FAIL bubble_order: got %0d words expected 1,2", got.size());
    end
  endtask

  task automatic test_reset_mid();
    int outs_before;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = DW'(i + 1);
      step();
    end
    checks++;
    if (count !== CW'(3)) begin errors++; $display("FAIL rmid_fill: got %0d expected 3", count); end
    s_valid = 1'b0;
    RESET   = 1'b0;
    step();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || count !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL rmid_state: got valid %0b ready %0b count %0d data %0h expected 0 0 0 0",
               m_valid, s_ready, count, m_data);
    end
    RESET = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: got ready %0b valid %0b expected ready 1 valid 0", s_ready, m_valid);
    end
    outs_before = n_out;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (n_out != outs_before) begin errors++; $display("FAIL rmid_stale: got %0d outputs expected 0", n_out - outs_before); end
  endtask

  task automatic test_passthru();
    s_valid = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      z_s_valid = 1'($urandom_range(0, 1));
      z_m_ready = 1'($urandom_range(0, 1));
      z_s_data  = DW'($urandom);
      #1;
      checks++;
      if (z_m_valid !== z_s_valid || z_m_data !== z_s_data || z_s_ready !== z_m_ready || z_count !== 1'b0) begin
        errors++;
        $display("FAIL passthru: got valid %0b data %0h ready %0b count %0d expected %0b %0h %0b 0",
                 z_m_valid, z_m_data, z_s_ready, z_count, z_s_valid, z_s_data, z_m_ready);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_pulse();
    test_bubble();
    test_reset_mid();
    test_passthru();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
